display_pio_master: RTL and testbench

//  Avalon-MM initiator that drives the 4-bit DISPLAY PIO output slave (data reg @0, outset @4, outclear @5).

---
 rtl/display_pio_pkg.sv | 30 +++
 rtl/display_pio_master_if.sv | 34 +++
 rtl/display_cmd_fifo.sv | 50 +++++
 rtl/display_pio_master.sv | 130 +++++++++++++
 tb/tb_display_pio_master.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/display_pio_pkg.sv
// Shared types and constants for the display PIO Avalon-MM initiator.
// Covers the command opcodes, PIO register addresses and FSM states.
package display_pio_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_SET   = 2'd1,
    OP_CLEAR = 2'd2,
    OP_READ  = 2'd3
  } op_e;

  localparam logic [2:0] PIO_ADDR_DATA   = 3'd0;
  localparam logic [2:0] PIO_ADDR_OUTSET = 3'd4;
  localparam logic [2:0] PIO_ADDR_OUTCLR = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  function automatic logic [2:0] op_addr(input op_e op);
    case (op)
      OP_SET:   return PIO_ADDR_OUTSET;
      OP_CLEAR: return PIO_ADDR_OUTCLR;
      default:  return PIO_ADDR_DATA;
    endcase
  endfunction

endpackage

// File: rtl/display_pio_master_if.sv
// Command stream, response stream and Avalon-MM bus of the display PIO initiator.
// The master modport is the initiator's view; slave is the surrounding fabric/PIO view.
interface display_pio_master_if #(
  parameter int DATA_W = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_error;
  logic [DATA_W-1:0] shadow;
  logic [2:0]        avm_address;
  logic              avm_chipselect;
  logic              avm_write_n;
  logic              avm_read;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready, avm_readdata, avm_waitrequest,
    output cmd_ready, rsp_valid, rsp_data, rsp_error, shadow,
    output avm_address, avm_chipselect, avm_write_n, avm_read, avm_writedata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, rsp_ready, avm_readdata, avm_waitrequest,
    input  cmd_ready, rsp_valid, rsp_data, rsp_error, shadow,
    input  avm_address, avm_chipselect, avm_write_n, avm_read, avm_writedata
  );
endinterface

// File: rtl/display_cmd_fifo.sv
// Synchronous {op, data} command FIFO; extra pointer bit separates full from empty.
// A push while full is taken only when a pop happens in the same cycle.
module display_cmd_fifo
  import display_pio_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  op_e               push_op,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output op_e               pop_op,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W+1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign pop_op   = op_e'(mem[rd_ptr[AW-1:0]][DATA_W+1:DATA_W]);
  assign pop_data = mem[rd_ptr[AW-1:0]][DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= {push_op, push_data};
  end

endmodule

// File: rtl/display_pio_master.sv
// Avalon-MM initiator driving the 4-bit DISPLAY PIO from a buffered command stream.
// One bus transfer and one response per command; keeps a shadow of the PIO output.
module display_pio_master
  import display_pio_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  display_pio_master_if.master bus
);
  localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_e            state, state_nxt;
  op_e               op_r;
  logic [DATA_W-1:0] data_r;
  logic [DATA_W-1:0] shadow_r;
  logic [7:0]        to_cnt;
  logic              err_r;
  logic              accept_en;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  op_e               fifo_op;
  logic [DATA_W-1:0] fifo_data;
  logic              xfer_done, xfer_abort;
  logic              issue, is_write;
  logic              unused_readdata;

  function automatic logic [DATA_W-1:0] next_shadow(input op_e op,
                                                    input logic [DATA_W-1:0] cur,
                                                    input logic [DATA_W-1:0] dat,
                                                    input logic [DATA_W-1:0] rd);
    case (op)
      OP_WRITE: return dat;
      OP_SET:   return cur | dat;
      OP_CLEAR: return cur & ~dat;
      default:  return rd;
    endcase
  endfunction

  assign unused_readdata = ^bus.avm_readdata[31:DATA_W];

  // accept_en holds cmd_ready low through reset and the first cycle after it
  assign bus.cmd_ready = accept_en && !fifo_full;
  assign fifo_push     = bus.cmd_valid && bus.cmd_ready;

  display_cmd_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_op   (op_e'(bus.cmd_op)),
    .push_data (bus.cmd_data),
    .pop       (fifo_pop),
    .pop_op    (fifo_op),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_nxt  = state;
    fifo_pop   = 1'b0;
    xfer_done  = 1'b0;
    xfer_abort = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) begin
        fifo_pop  = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: if (!bus.avm_waitrequest) begin
        xfer_done = 1'b1;
        state_nxt = RESP;
      end else if (TIMEOUT != 0 && to_cnt == TO_LAST) begin
        xfer_abort = 1'b1;
        state_nxt  = RESP;
      end
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      shadow_r  <= '0;
      to_cnt    <= '0;
      err_r     <= 1'b0;
      accept_en <= 1'b0;
    end else begin
      state     <= state_nxt;
      accept_en <= 1'b1;
      if (fifo_pop)
        to_cnt <= '0;
      else if (state == ISSUE && bus.avm_waitrequest)
        to_cnt <= to_cnt + 8'd1;
      if (xfer_done) begin
        shadow_r <= next_shadow(op_r, shadow_r, data_r, bus.avm_readdata[DATA_W-1:0]);
        err_r    <= 1'b0;
      end
      if (xfer_abort) err_r <= 1'b1;
    end
  end

  // command registers are always loaded before ISSUE, so they need no reset
  always_ff @(posedge clk) begin
    if (fifo_pop) begin
      op_r   <= fifo_op;
      data_r <= fifo_data;
    end
  end

  assign issue    = (state == ISSUE);
  assign is_write = issue && (op_r != OP_READ);

  assign bus.avm_chipselect = issue;
  assign bus.avm_write_n    = !is_write;
  assign bus.avm_read       = issue && (op_r == OP_READ);
  assign bus.avm_address    = issue ? op_addr(op_r) : 3'd0;
  assign bus.avm_writedata  = is_write ? 32'(data_r) : 32'd0;

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = shadow_r;
  assign bus.rsp_error = err_r;
  assign bus.shadow    = shadow_r;

endmodule

// File: tb/tb_display_pio_master.sv
// Directed bench for display_pio_master against a small DISPLAY PIO slave model.
module tb_display_pio_master;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       wait_force;
  logic [3:0] out_port;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  display_pio_master_if #(.DATA_W(4)) bus ();

  display_pio_master #(
    .DATA_W     (4),
    .FIFO_DEPTH (4),
    .TIMEOUT    (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // PIO slave: data @0, outset @4, outclear @5
  assign bus.avm_waitrequest = wait_force;
  assign bus.avm_readdata    = (bus.avm_address == 3'd0) ? {28'h0, out_port} : 32'h0;

  always @(posedge clk) begin
    if (!reset_n) out_port <= 4'h0;
    else if (bus.avm_chipselect && !bus.avm_write_n && !wait_force) begin
      case (bus.avm_address)
        3'd0: out_port <= bus.avm_writedata[3:0];
        3'd4: out_port <= out_port | bus.avm_writedata[3:0];
        3'd5: out_port <= out_port & ~bus.avm_writedata[3:0];
        default: ;
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset_n       = 1'b0;
    wait_force    = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd0;
    bus.cmd_data  = 4'hF;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_cmd_ready got=%b want=0", bus.cmd_ready); end
    total++; if (bus.avm_chipselect !== 1'b0 || bus.avm_write_n !== 1'b1 || bus.avm_read !== 1'b0) begin
      bad++; $display("FAIL reset_strobes got cs=%b wn=%b rd=%b want cs=0 wn=1 rd=0", bus.avm_chipselect, bus.avm_write_n, bus.avm_read);
    end
    total++; if (bus.avm_address !== 3'd0 || bus.avm_writedata !== 32'd0) begin
      bad++; $display("FAIL reset_addr_wd got addr=%0d wd=%h want 0/0", bus.avm_address, bus.avm_writedata);
    end
    total++; if (bus.shadow !== 4'h0 || bus.rsp_data !== 4'h0) begin
      bad++; $display("FAIL reset_shadow got shadow=%h rsp_data=%h want 0", bus.shadow, bus.rsp_data);
    end
    total++; if (bus.rsp_valid !== 1'b0 || bus.rsp_error !== 1'b0) begin
      bad++; $display("FAIL reset_rsp got valid=%b err=%b want 0/0", bus.rsp_valid, bus.rsp_error);
    end
    @(posedge clk); #1;
    reset_n       = 1'b1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL release_ready_early got=%b want=0", bus.cmd_ready); end
    @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b want=1", bus.cmd_ready); end
  endtask

  task automatic test_write();
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0; bus.cmd_data = 4'hA;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.avm_chipselect !== 1'b0) begin bad++; $display("FAIL write_latency cs got=%b want=0", bus.avm_chipselect); end
    @(negedge clk);
    total++; if (bus.avm_chipselect !== 1'b1 || bus.avm_write_n !== 1'b0 || bus.avm_read !== 1'b0) begin
      bad++; $display("FAIL write_strobes got cs=%b wn=%b rd=%b want 1/0/0", bus.avm_chipselect, bus.avm_write_n, bus.avm_read);
    end
    total++; if (bus.avm_address !== 3'd0) begin bad++; $display("FAIL write_addr got=%0d want=0", bus.avm_address); end
    total++; if (bus.avm_writedata !== 32'h0000000A) begin bad++; $display("FAIL write_wd got=%h want=0000000a", bus.avm_writedata); end
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 4'hA || bus.rsp_error !== 1'b0) begin
      bad++; $display("FAIL write_rsp got v=%b d=%h e=%b want 1/a/0", bus.rsp_valid, bus.rsp_data, bus.rsp_error);
    end
    total++; if (bus.avm_chipselect !== 1'b0) begin bad++; $display("FAIL write_cs_in_resp got=%b want=0", bus.avm_chipselect); end
    total++; if (out_port !== 4'hA) begin bad++; $display("FAIL write_out_port got=%h want=a", out_port); end
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL write_rsp_hold got=%b want=1", bus.rsp_valid); end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL write_rsp_drop got=%b want=0", bus.rsp_valid); end
  endtask

  task automatic test_set_clear_read();
    logic [1:0] ops  [3] = '{2'd1, 2'd2, 2'd3};
    logic [3:0] dats [3] = '{4'h5, 4'h8, 4'h0};
    logic [2:0] addrs[3] = '{3'd4, 3'd5, 3'd0};
    logic [3:0] exps [3] = '{4'hF, 4'h7, 4'h7};
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.cmd_valid = 1'b1; bus.cmd_op = ops[i]; bus.cmd_data = dats[i];
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      total++; if (bus.avm_chipselect !== 1'b1 || bus.avm_address !== addrs[i]) begin
        bad++; $display("FAIL scr_addr[%0d] got cs=%b addr=%0d want 1/%0d", i, bus.avm_chipselect, bus.avm_address, addrs[i]);
      end
      total++; if (bus.avm_read !== (ops[i] == 2'd3) || bus.avm_write_n !== (ops[i] == 2'd3)) begin
        bad++; $display("FAIL scr_strobe[%0d] got rd=%b wn=%b op=%0d", i, bus.avm_read, bus.avm_write_n, ops[i]);
      end
      @(negedge clk);
      total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exps[i] || bus.rsp_error !== 1'b0) begin
        bad++; $display("FAIL scr_rsp[%0d] got v=%b d=%h e=%b want 1/%h/0", i, bus.rsp_valid, bus.rsp_data, bus.rsp_error, exps[i]);
      end
      total++; if (out_port !== exps[i]) begin bad++; $display("FAIL scr_out_port[%0d] got=%h want=%h", i, out_port, exps[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops [5] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd0};
    logic [3:0] dats[5] = '{4'h1, 4'h2, 4'h4, 4'h1, 4'h9};
    logic [3:0] exps[5] = '{4'h1, 4'h3, 4'h7, 4'h6, 4'h9};
    int k = 0;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.cmd_valid = 1'b1; bus.cmd_op = ops[i]; bus.cmd_data = dats[i];
      @(negedge clk);
      total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_accept[%0d] got=%b want=1", i, bus.cmd_ready); end
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_full got ready=%b want=0", bus.cmd_ready); end
    bus.rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && k < 5; cyc++) begin
      if (bus.rsp_valid === 1'b1) begin
        total++; if (bus.rsp_data !== exps[k] || bus.rsp_error !== 1'b0) begin
          bad++; $display("FAIL b2b_rsp[%0d] got d=%h e=%b want %h/0", k, bus.rsp_data, bus.rsp_error, exps[k]);
        end
        k++;
      end
      if (k < 5) @(negedge clk);
    end
    total++; if (k != 5) begin bad++; $display("FAIL b2b_count got=%0d want=5", k); end
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_back got=%b want=1", bus.cmd_ready); end
  endtask

  task automatic test_timeout();
    int cs_cnt = 0;
    bit got = 0;
    @(posedge clk); #1;
    wait_force    = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1; bus.cmd_data = 4'h6;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 30 && !got; cyc++) begin
      @(negedge clk);
      if (bus.avm_chipselect === 1'b1) cs_cnt++;
      if (bus.rsp_valid === 1'b1) got = 1;
    end
    total++; if (!got) begin bad++; $display("FAIL to_rsp_wait got no response within 30 cycles"); end
    total++; if (cs_cnt != 8) begin bad++; $display("FAIL to_strobe_cycles got=%0d want=8", cs_cnt); end
    total++; if (bus.rsp_error !== 1'b1 || bus.rsp_data !== 4'h9) begin
      bad++; $display("FAIL to_rsp got e=%b d=%h want 1/9", bus.rsp_error, bus.rsp_data);
    end
    total++; if (bus.shadow !== 4'h9 || out_port !== 4'h9) begin
      bad++; $display("FAIL to_shadow got shadow=%h out=%h want 9/9", bus.shadow, out_port);
    end
    wait_force = 1'b0;
    cs_cnt = 0; got = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd2; bus.cmd_data = 4'h8;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 30 && !got; cyc++) begin
      @(negedge clk);
      if (bus.avm_chipselect === 1'b1) cs_cnt++;
      if (bus.rsp_valid === 1'b1) got = 1;
    end
    total++; if (!got || cs_cnt != 1) begin bad++; $display("FAIL to_next_cmd got rsp=%0d cs_cycles=%0d want 1/1", got, cs_cnt); end
    total++; if (bus.rsp_error !== 1'b0 || bus.rsp_data !== 4'h1) begin
      bad++; $display("FAIL to_next_rsp got e=%b d=%h want 0/1", bus.rsp_error, bus.rsp_data);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    @(posedge clk); #1;
    wait_force    = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0; bus.cmd_data = 4'h3;
    @(posedge clk); #1;
    bus.cmd_data  = 4'h5;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.avm_chipselect !== 1'b1) begin bad++; $display("FAIL rmid_in_issue got cs=%b want=1", bus.avm_chipselect); end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (bus.avm_chipselect !== 1'b0 || bus.avm_write_n !== 1'b1 || bus.avm_read !== 1'b0) begin
      bad++; $display("FAIL rmid_strobes got cs=%b wn=%b rd=%b want 0/1/0", bus.avm_chipselect, bus.avm_write_n, bus.avm_read);
    end
    total++; if (bus.shadow !== 4'h0 || bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rmid_state got shadow=%h rsp_valid=%b want 0/0", bus.shadow, bus.rsp_valid);
    end
    wait_force = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (bus.avm_chipselect === 1'b1 || bus.rsp_valid === 1'b1) seen = 1;
    end
    total++; if (seen) begin bad++; $display("FAIL rmid_fifo_flushed got activity=1 want=0"); end
    total++; if (bus.cmd_ready !== 1'b1 || bus.shadow !== 4'h0) begin
      bad++; $display("FAIL rmid_after got ready=%b shadow=%h want 1/0", bus.cmd_ready, bus.shadow);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_set_clear_read();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
